// File: rtl/traffic_ctrl_nch.sv
// Round-robin traffic-light controller for NUM_CH approaches with bounded green,
// amber flash mode and a TEST mode that shortens every timed interval to one cycle.
module traffic_ctrl_nch #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned TW        = 8,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YLW_T     = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned FLASH_T   = 3
) (
    input  logic              CK,
    input  logic              CLRN,
    input  logic [NUM_CH-1:0] REQ,
    input  logic              TEST,
    input  logic              FLASH,
    output logic [NUM_CH-1:0] GRN,
    output logic [NUM_CH-1:0] YLW,
    output logic [NUM_CH-1:0] RED,
    output logic [2:0]        ACTIVE,
    output logic [1:0]        PHASE
);

    localparam logic [TW-1:0]     ALLRED_LD = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0]     YLW_LD    = TW'(YLW_T - 1);
    localparam logic [TW-1:0]     FLASH_LD  = TW'(FLASH_T - 1);
    localparam logic [TW-1:0]     GMIN_M1   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0]     GMAX_M1   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0]     GCNT_SAT  = {TW{1'b1}};
    localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_CH    = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       r_gcnt;
    logic [2:0]          r_active;
    logic [NUM_CH-1:0]   r_pending;
    logic                r_blink;
    logic [NUM_CH-1:0]   r_grn;
    logic [NUM_CH-1:0]   r_ylw;
    logic [NUM_CH-1:0]   r_red;

    state_t              w_state_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [TW-1:0]       w_gcnt_nxt;
    logic [2:0]          w_active_nxt;
    logic [NUM_CH-1:0]   w_pending_nxt;
    logic                w_blink_nxt;
    logic [NUM_CH-1:0]   w_grn_nxt;
    logic [NUM_CH-1:0]   w_ylw_nxt;
    logic [NUM_CH-1:0]   w_red_nxt;

    logic [2:0]          w_rr_pick;
    logic [NUM_CH-1:0]   w_act_oh;
    logic [NUM_CH-1:0]   w_pick_oh;
    logic [NUM_CH-1:0]   w_nxt_oh;
    logic                w_other;
    logic                w_act_pend;
    logic                w_act_req;
    logic                w_leave_green;
    logic [TW-1:0]       w_gmin_m1;
    logic [TW-1:0]       w_gmax_m1;
    logic [TW-1:0]       w_allred_ld;
    logic [TW-1:0]       w_ylw_ld;
    logic [TW-1:0]       w_flash_ld;
    logic [TW-1:0]       w_timer_dec;

    // Timing values collapse to a single cycle while TEST is high
    assign w_allred_ld = TEST ? '0 : ALLRED_LD;
    assign w_ylw_ld    = TEST ? '0 : YLW_LD;
    assign w_flash_ld  = TEST ? '0 : FLASH_LD;
    assign w_gmin_m1   = TEST ? '0 : GMIN_M1;
    assign w_gmax_m1   = TEST ? '0 : GMAX_M1;
    assign w_timer_dec = r_timer - TW'(1);

    assign w_act_oh   = ONE_CH << r_active;
    assign w_pick_oh  = ONE_CH << w_rr_pick;
    assign w_other    = |(r_pending & ~w_act_oh);
    assign w_act_pend = |(r_pending & w_act_oh);
    assign w_act_req  = |(REQ & w_act_oh);

    assign w_leave_green = w_other &&
        (((r_gcnt >= w_gmin_m1) && !w_act_pend && !w_act_req) || (r_gcnt >= w_gmax_m1));

    // Nearest pending approach after the current one, wrapping; plain successor if none
    always_comb begin
        int v_dist;
        int v_best;
        w_rr_pick = (r_active == LAST_CH) ? 3'd0 : r_active + 3'd1;
        v_best    = int'(NUM_CH) + 1;
        v_dist    = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            v_dist = i - int'(r_active);
            if (v_dist <= 0) begin
                v_dist = v_dist + int'(NUM_CH);
            end
            if (r_pending[i] && (v_dist < v_best)) begin
                v_best    = v_dist;
                w_rr_pick = 3'(i);
            end
        end
    end

    // Next-state logic: flash request overrides all timer and green rules
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_gcnt_nxt    = r_gcnt;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending | REQ;
        w_blink_nxt   = r_blink;

        if (FLASH) begin
            w_state_nxt = S_FLASH;
            if (r_state != S_FLASH) begin
                w_blink_nxt = 1'b1;
                w_timer_nxt = w_flash_ld;
            end else if (r_timer == '0) begin
                w_blink_nxt = ~r_blink;
                w_timer_nxt = w_flash_ld;
            end else begin
                w_timer_nxt = w_timer_dec;
            end
        end else begin
            case (r_state)
                S_ALLRED: begin
                    if (r_timer == '0) begin
                        w_state_nxt   = S_GREEN;
                        w_active_nxt  = w_rr_pick;
                        w_gcnt_nxt    = '0;
                        w_pending_nxt = (r_pending & ~w_pick_oh) | REQ;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end
                S_GREEN: begin
                    w_gcnt_nxt = (r_gcnt == GCNT_SAT) ? r_gcnt : r_gcnt + TW'(1);
                    if (w_leave_green) begin
                        w_state_nxt = S_YELLOW;
                        w_timer_nxt = w_ylw_ld;
                    end
                end
                S_YELLOW: begin
                    if (r_timer == '0) begin
                        w_state_nxt = S_ALLRED;
                        w_timer_nxt = w_allred_ld;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end
                default: begin
                    w_state_nxt  = S_ALLRED;
                    w_timer_nxt  = w_allred_ld;
                    w_active_nxt = LAST_CH;
                end
            endcase
        end
    end

    // Lamp decode of the next state so the lamp registers track the state register
    always_comb begin
        w_nxt_oh  = ONE_CH << w_active_nxt;
        w_grn_nxt = '0;
        w_ylw_nxt = '0;
        w_red_nxt = '1;
        case (w_state_nxt)
            S_GREEN: begin
                w_grn_nxt = w_nxt_oh;
                w_red_nxt = ~w_nxt_oh;
            end
            S_YELLOW: begin
                w_ylw_nxt = w_nxt_oh;
                w_red_nxt = ~w_nxt_oh;
            end
            S_FLASH: begin
                w_ylw_nxt = {NUM_CH{w_blink_nxt}};
                w_red_nxt = '0;
            end
            default: begin
                w_red_nxt = '1;
            end
        endcase
    end

    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            r_state   <= S_ALLRED;
            r_timer   <= ALLRED_LD;
            r_gcnt    <= '0;
            r_active  <= LAST_CH;
            r_pending <= '0;
            r_blink   <= 1'b1;
            r_grn     <= '0;
            r_ylw     <= '0;
            r_red     <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_blink   <= w_blink_nxt;
            r_grn     <= w_grn_nxt;
            r_ylw     <= w_ylw_nxt;
            r_red     <= w_red_nxt;
        end
    end

    assign GRN    = r_grn;
    assign YLW    = r_ylw;
    assign RED    = r_red;
    assign ACTIVE = r_active;
    assign PHASE  = r_state;

endmodule
